// File: rtl/nibble_serial_sub16.sv
// Digit-serial subtractor: Diff = A - B - Bin, one DIGIT-wide slice per clock,
// LSB slice first, with a registered borrow chained between slices.
module nibble_serial_sub16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned NSLICE = WIDTH / DIGIT;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
  logic             a_msb_q, b_msb_q, borrow_q, bout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0]       a_k, b_k;
  logic [DIGIT:0]         slice;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [WIDTH-1:0]       res_next;
  logic                   last, ovf_next, accept, release_out;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign release_out = out_valid & out_ready;
  assign Diff        = diff_q;
  assign Bout        = bout_q;
  assign Ovf         = ovf_q;

  // Operands are shifted right each BUSY cycle, so the current slice is
  // always at the bottom; the sign bits are kept aside for the overflow term.
  always_comb begin
    a_k      = a_q[DIGIT-1:0];
    b_k      = b_q[DIGIT-1:0];
    slice    = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, borrow_q};
    cat      = {slice[DIGIT-1:0], res_q};
    res_next = cat[WIDTH+DIGIT-1:DIGIT];
    last     = (cnt_q == CW'(NSLICE - 1));
    ovf_next = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_next[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && accept) begin
        a_q      <= A;
        b_q      <= B;
        a_msb_q  <= A[WIDTH-1];
        b_msb_q  <= B[WIDTH-1];
        borrow_q <= Bin;
        cnt_q    <= '0;
      end else if (state_q == BUSY) begin
        a_q      <= a_q >> DIGIT;
        b_q      <= b_q >> DIGIT;
        borrow_q <= slice[DIGIT];
        res_q    <= res_next;
        if (last) begin
          diff_q <= res_next;
          bout_q <= slice[DIGIT];
          ovf_q  <= ovf_next;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Self-checking bench for nibble_serial_sub16: directed test-plan cases plus
// random operands against an integer-arithmetic reference.
module tb_nibble_serial_sub16;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned NS = W / D;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready, Bin;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, Bout, Ovf;
  logic [W-1:0] Diff;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] last_diff;
  logic         last_bout, last_ovf;

  nibble_serial_sub16 #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    longint u, s;
    u  = longint'(a) - longint'(b) - longint'(bin);
    s  = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    d  = W'(u);
    bo = (u < 0);
    ov = (s > 32767) || (s < -32768);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input int hold);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           w;
    model(a, b, bin, ed, eb, eo);
    @(negedge clk);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    for (int n = 0; n <= int'(NS); n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (n < int'(NS)) begin
        chk("busy_out_valid", out_valid, 0);
        chk("busy_in_ready", in_ready, 0);
        chk("busy_diff_hold", Diff, last_diff);
        chk("busy_bout_hold", Bout, last_bout);
      end else begin
        chk("latency_out_valid", out_valid, 1);
      end
    end
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("diff", Diff, ed);
    chk("bout", Bout, eb);
    chk("ovf", Ovf, eo);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_diff", Diff, ed);
      chk("bp_bout", Bout, eb);
      chk("bp_ovf", Ovf, eo);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_diff_hold", Diff, ed);
    last_diff = ed;
    last_bout = eb;
    last_ovf  = eo;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Bin = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", Diff, 0);
    chk("rst_bout", Bout, 0);
    chk("rst_ovf", Ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    run_op(16'h1234, 16'h0034, 1'b0, 0);
    chk("tp1_diff_const", Diff, 16'h1200);
    run_op(16'h0000, 16'h0001, 1'b0, 0);
    chk("tp2_diff_const", Diff, 16'hFFFF);
    chk("tp2_bout_const", Bout, 1);
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    chk("tp3a_ovf_const", Ovf, 1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 1);
    chk("tp3b_diff_const", Diff, 16'h8000);
    run_op(16'h1000, 16'h0FFF, 1'b1, 0);
    chk("tp4a_diff_const", Diff, 16'h0000);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    chk("tp4b_bout_const", Bout, 1);
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 10);

    // Reset during the second BUSY cycle aborts the operation.
    @(negedge clk);
    A = 16'h4321; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_diff", Diff, 0);
    chk("abort_bout", Bout, 0);
    chk("abort_ovf", Ovf, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    repeat (NS + 1) begin
      @(negedge clk);
      chk("abort_no_result", out_valid, 0);
    end
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    run_op(16'h0005, 16'h0003, 1'b0, 0);
    chk("tp6_diff_const", Diff, 16'h0002);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
